// File: rtl/out_arbiter_pkg.sv
// Shared router definitions: arbiter state encoding, default sizes and
// a width helper used to size pointers and counters.
package out_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int NPORT_DEF  = 5;
    localparam int MAXLEN_DEF = 16;

    // Ceiling log2, floored at 1 so the result can always size a vector.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/out_arbiter_if.sv
// Request/grant bundle between the input buffers, the output mux and
// one output-port arbiter.
interface out_arbiter_if
    import out_arbiter_pkg::*;
#(
    parameter int NPORT = NPORT_DEF
);
    logic [NPORT-1:0] req;
    logic [NPORT-1:0] tail;
    logic             out_ready;
    logic [NPORT-1:0] index;
    logic             out_valid;
    logic [NPORT-1:0] ack;
    logic             overrun;

    // master: the arbiter; slave: buffers, mux and downstream side
    modport master (
        input  req, tail, out_ready,
        output index, out_valid, ack, overrun
    );
    modport slave (
        output req, tail, out_ready,
        input  index, out_valid, ack, overrun
    );
endinterface

// File: rtl/out_arbiter_rr_select.sv
// Combinational round-robin pick: first set req bit searching ptr, ptr+1, ...
// with wrap. Shared with the input-side arbiters.
module rr_select
    import out_arbiter_pkg::*;
#(
    parameter int N  = NPORT_DEF,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] winner
);

    assign any = |req;

    // Walk the search order backwards so the earliest candidate is written last.
    always_comb begin
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N])
                winner = PW'((int'(ptr) + k) % N);
        end
    end

endmodule

// File: rtl/out_arbiter.sv
// Per-output packet arbiter: round-robin grant held for a whole packet,
// released on tail or after MAXLEN flits, popping the owner on every flit.
module out_arbiter
    import out_arbiter_pkg::*;
#(
    parameter int NPORT  = NPORT_DEF,
    parameter int MAXLEN = MAXLEN_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    out_arbiter_if.master bus
);

    localparam int PW = clog2(NPORT);
    localparam int CW = clog2(MAXLEN);
    localparam logic [PW-1:0] PTR_LAST = PW'(NPORT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAXLEN - 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    own;
    logic [PW-1:0]    winner;
    logic [CW-1:0]    cnt;
    logic             any;
    logic [NPORT-1:0] own_oh;
    logic             owner_req;
    logic             owner_tail;
    logic             at_limit;
    logic             xfer;
    logic             rel;

    rr_select #(.N(NPORT), .PW(PW)) u_sel (
        .req    (bus.req),
        .ptr    (ptr),
        .any    (any),
        .winner (winner)
    );

    assign own_oh     = NPORT'(1) << own;
    assign owner_req  = bus.req[own];
    assign owner_tail = bus.tail[own];
    assign at_limit   = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any) state_nxt = BUSY;
            BUSY:    if (rel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A flit held in reset is not popped, so an aborted packet loses no data.
    always_comb begin
        bus.index     = '0;
        bus.out_valid = 1'b0;
        bus.ack       = '0;
        bus.overrun   = 1'b0;
        xfer          = 1'b0;
        rel           = 1'b0;
        if (state == BUSY) begin
            bus.index     = own_oh;
            bus.out_valid = owner_req;
            xfer          = owner_req & bus.out_ready & rst_n;
            bus.ack       = xfer ? own_oh : '0;
            rel           = xfer & (owner_tail | at_limit);
            bus.overrun   = xfer & at_limit & ~owner_tail;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
            own <= '0;
            cnt <= '0;
        end else if (state == IDLE) begin
            if (any) begin
                own <= winner;
                cnt <= '0;
            end
        end else if (xfer) begin
            cnt <= cnt + 1'b1;
            if (rel)
                ptr <= (own == PTR_LAST) ? '0 : own + 1'b1;
        end
    end

endmodule

// File: tb/tb_out_arbiter.sv
// Self-checking bench for out_arbiter: directed scenarios plus random traffic
// against a packet-level reference model.
module tb_out_arbiter;
    import out_arbiter_pkg::*;

    localparam int NP = 5;
    localparam int ML = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    bit   m_busy = 1'b0;
    int   m_own = 0;
    int   m_ptr = 0;
    int   m_flits = 0;

    out_arbiter_if #(.NPORT(NP)) bus ();

    out_arbiter #(.NPORT(NP), .MAXLEN(ML)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [NP-1:0] e_index();
        return m_busy ? (NP'(1) << m_own) : '0;
    endfunction

    function automatic logic e_valid();
        return m_busy && bus.req[m_own];
    endfunction

    function automatic logic e_xfer();
        return e_valid() && bus.out_ready && rst_n;
    endfunction

    function automatic logic [NP-1:0] e_ack();
        return e_xfer() ? e_index() : '0;
    endfunction

    function automatic logic e_overrun();
        return e_xfer() && (m_flits == ML - 1) && !bus.tail[m_own];
    endfunction

    // One clock: the model consumes the inputs presented for this cycle.
    task automatic tick();
        logic [NP-1:0] r;
        logic [NP-1:0] t;
        logic          rdy;
        logic          rn;
        r   = bus.req;
        t   = bus.tail;
        rdy = bus.out_ready;
        rn  = rst_n;
        @(posedge clk);
        if (!rn) begin
            m_busy = 0; m_own = 0; m_ptr = 0; m_flits = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < NP; k++) begin
                if (r[(m_ptr + k) % NP]) begin
                    m_own = (m_ptr + k) % NP;
                    m_busy = 1;
                    m_flits = 0;
                    break;
                end
            end
        end else if (r[m_own] && rdy) begin
            m_flits++;
            if (t[m_own] || m_flits == ML) begin
                m_busy = 0;
                m_ptr = (m_own + 1) % NP;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.req = NP'($urandom);
        bus.tail = NP'($urandom);
        bus.out_ready = 1;
        tick();
        tick();
        #1;
        n_chk++; if (bus.index !== '0) begin n_fail++; $display("FAIL reset_index: got %b want 0", bus.index); end
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_chk++; if (bus.ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
        n_chk++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
        n_chk++; if (dut.ptr !== 3'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr); end
        n_chk++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
    endtask

    task automatic test_single_packet();
        int acks = 0;
        rst_n = 1;
        bus.req = 5'b00100;
        bus.tail = '0;
        bus.out_ready = 1;
        #1;
        n_chk++; if (bus.index !== '0) begin n_fail++; $display("FAIL single_idle_index: got %b want 0", bus.index); end
        tick();
        for (int f = 0; f < 3; f++) begin
            bus.tail = (f == 2) ? 5'b00100 : 5'b00000;
            #1;
            n_chk++; if (bus.index !== 5'b00100) begin n_fail++; $display("FAIL single_index: flit %0d got %b want 00100", f, bus.index); end
            n_chk++; if (bus.ack !== e_ack()) begin n_fail++; $display("FAIL single_ack: flit %0d got %b want %b", f, bus.ack, e_ack()); end
            if (bus.ack[2]) acks++;
            tick();
        end
        bus.req = '0;
        bus.tail = '0;
        #1;
        n_chk++; if (acks != 3) begin n_fail++; $display("FAIL single_ack_count: got %0d want 3", acks); end
        n_chk++; if (bus.index !== '0) begin n_fail++; $display("FAIL single_release_index: got %b want 0", bus.index); end
        n_chk++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL single_state: got %0d want IDLE", dut.state); end
        n_chk++; if (dut.ptr !== 3'd3) begin n_fail++; $display("FAIL single_ptr: got %0d want 3", dut.ptr); end
        tick();
    endtask

    task automatic test_rr_order();
        logic [NP-1:0] pending = 5'b10011;
        int seen[$];
        bus.tail = 5'b11111;
        bus.out_ready = 1;
        for (int c = 0; c < 10; c++) begin
            bus.req = pending;
            #1;
            n_chk++; if ($countones(bus.index) > 1) begin n_fail++; $display("FAIL rr_onehot: cycle %0d index %b", c, bus.index); end
            n_chk++; if (bus.index !== e_index()) begin n_fail++; $display("FAIL rr_index: cycle %0d got %b want %b", c, bus.index, e_index()); end
            if (|bus.ack) begin
                seen.push_back($clog2(bus.ack));
                pending = pending & ~bus.ack;
            end
            tick();
        end
        n_chk++;
        if (seen.size() != 3 || seen[0] != 4 || seen[1] != 0 || seen[2] != 1) begin
            n_fail++;
            $display("FAIL rr_order: got %p want 4 0 1", seen);
        end
        bus.req = '0;
        bus.tail = '0;
    endtask

    task automatic test_stall();
        rst_n = 0;
        tick();
        rst_n = 1;
        bus.req = 5'b00001; bus.tail = 5'b00001; bus.out_ready = 1;
        tick();
        tick();
        bus.req = 5'b00011; bus.tail = '0;
        tick();
        #1;
        n_chk++; if (bus.index !== 5'b00010) begin n_fail++; $display("FAIL stall_grant: got %b want 00010", bus.index); end
        tick();
        bus.out_ready = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_chk++; if (bus.ack !== '0) begin n_fail++; $display("FAIL stall_ack: cycle %0d got %b want 0", c, bus.ack); end
            n_chk++; if (bus.index !== 5'b00010) begin n_fail++; $display("FAIL stall_index: cycle %0d got %b want 00010", c, bus.index); end
            n_chk++; if (dut.cnt !== 2'd1) begin n_fail++; $display("FAIL stall_cnt: cycle %0d got %0d want 1", c, dut.cnt); end
            tick();
        end
        bus.out_ready = 1;
        bus.tail = 5'b00010;
        #1;
        n_chk++; if (bus.ack !== 5'b00010) begin n_fail++; $display("FAIL stall_resume_ack: got %b want 00010", bus.ack); end
        tick();
        bus.req = '0; bus.tail = '0;
        tick();
    endtask

    task automatic test_req_drop();
        bus.req = 5'b01000; bus.tail = '0; bus.out_ready = 1;
        tick();
        #1;
        n_chk++; if (bus.index !== 5'b01000) begin n_fail++; $display("FAIL drop_grant: got %b want 01000", bus.index); end
        tick();
        bus.req = 5'b10111;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid: cycle %0d got %b want 0", c, bus.out_valid); end
            n_chk++; if (bus.index !== 5'b01000) begin n_fail++; $display("FAIL drop_index: cycle %0d got %b want 01000", c, bus.index); end
            n_chk++; if (bus.ack !== '0) begin n_fail++; $display("FAIL drop_ack: cycle %0d got %b want 0", c, bus.ack); end
            tick();
        end
        bus.req = 5'b01000;
        for (int f = 0; f < 2; f++) begin
            bus.tail = (f == 1) ? 5'b01000 : 5'b00000;
            #1;
            n_chk++; if (bus.ack !== 5'b01000) begin n_fail++; $display("FAIL drop_resume_ack: flit %0d got %b want 01000", f, bus.ack); end
            n_chk++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL drop_overrun: flit %0d got %b want 0", f, bus.overrun); end
            tick();
        end
        bus.req = '0; bus.tail = '0;
        #1;
        n_chk++; if (bus.index !== '0) begin n_fail++; $display("FAIL drop_release: got %b want 0", bus.index); end
    endtask

    task automatic test_maxlen();
        bus.req = 5'b00001; bus.tail = '0; bus.out_ready = 1;
        tick();
        for (int f = 0; f < ML; f++) begin
            #1;
            n_chk++; if (bus.ack !== 5'b00001) begin n_fail++; $display("FAIL maxlen_ack: flit %0d got %b want 00001", f, bus.ack); end
            n_chk++; if (bus.overrun !== (f == ML - 1)) begin n_fail++; $display("FAIL maxlen_overrun: flit %0d got %b want %b", f, bus.overrun, f == ML - 1); end
            tick();
        end
        #1;
        n_chk++; if (bus.index !== '0) begin n_fail++; $display("FAIL maxlen_release: got %b want 0", bus.index); end
        tick();
        for (int f = 0; f < ML; f++) begin
            bus.tail = (f == ML - 1) ? 5'b00001 : 5'b00000;
            #1;
            n_chk++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL maxlen_tail_overrun: flit %0d got %b want 0", f, bus.overrun); end
            n_chk++; if (bus.ack !== 5'b00001) begin n_fail++; $display("FAIL maxlen_tail_ack: flit %0d got %b want 00001", f, bus.ack); end
            tick();
        end
        bus.req = '0; bus.tail = '0;
        #1;
        n_chk++; if (bus.index !== '0) begin n_fail++; $display("FAIL maxlen_tail_release: got %b want 0", bus.index); end
    endtask

    task automatic test_reset_mid();
        bus.req = 5'b00100; bus.tail = '0; bus.out_ready = 1;
        tick();
        tick();
        rst_n = 0;
        #1;
        n_chk++; if (bus.ack !== '0) begin n_fail++; $display("FAIL rstmid_ack_in_reset: got %b want 0", bus.ack); end
        tick();
        rst_n = 1;
        bus.req = '0;
        #1;
        n_chk++; if (bus.index !== '0) begin n_fail++; $display("FAIL rstmid_index: got %b want 0", bus.index); end
        n_chk++; if (bus.ack !== '0) begin n_fail++; $display("FAIL rstmid_ack: got %b want 0", bus.ack); end
        n_chk++; if (dut.ptr !== 3'd0) begin n_fail++; $display("FAIL rstmid_ptr: got %0d want 0", dut.ptr); end
        n_chk++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d want IDLE", dut.state); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.req = NP'($urandom);
            bus.tail = NP'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
            #1;
            n_chk++; if ($countones(bus.index) > 1) begin n_fail++; $display("FAIL rand_onehot: cycle %0d index %b", c, bus.index); end
            n_chk++; if (bus.index !== e_index()) begin n_fail++; $display("FAIL rand_index: cycle %0d got %b want %b", c, bus.index, e_index()); end
            n_chk++; if (bus.out_valid !== e_valid()) begin n_fail++; $display("FAIL rand_valid: cycle %0d got %b want %b", c, bus.out_valid, e_valid()); end
            n_chk++; if (bus.ack !== e_ack()) begin n_fail++; $display("FAIL rand_ack: cycle %0d got %b want %b", c, bus.ack, e_ack()); end
            n_chk++; if (bus.overrun !== e_overrun()) begin n_fail++; $display("FAIL rand_overrun: cycle %0d got %b want %b", c, bus.overrun, e_overrun()); end
            tick();
        end
        rst_n = 1;
    endtask

    initial begin
        bus.req = '0;
        bus.tail = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_packet();
        test_rr_order();
        test_stall();
        test_req_drop();
        test_maxlen();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
